// File: rtl/legv8_ctrl_pkg.sv
// Shared types for the LEGv8 control path: FSM states, opcode classes and
// the mux/select encodings also used by the sign-extend and ALU-control blocks.
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WR, S_WB_LD, S_BRANCH, S_JUMP
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL, CLS_B, CLS_CBZ, CLS_LD, CLS_ST, CLS_R
  } op_class_e;

  localparam logic [5:0]  OP_B_PFX   = 6'b000101;
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [10:0] OP_LDUR    = 11'b11111000010;
  localparam logic [10:0] OP_STUR    = 11'b11111000000;
  localparam logic [10:0] OP_ADD     = 11'b10001011000;
  localparam logic [10:0] OP_SUB     = 11'b11001011000;
  localparam logic [10:0] OP_AND     = 11'b10001010000;
  localparam logic [10:0] OP_ORR     = 11'b10101010000;

  typedef enum logic [1:0] {IMM_D = 2'b00, IMM_CB = 2'b01, IMM_B = 2'b10} imm_sel_e;
  typedef enum logic [1:0] {
    SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;
  typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_PASS_B = 2'b01, ALUOP_FUNCT = 2'b10} alu_op_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    imm_sel_e   imm_sel;
    logic       reg2loc;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
    logic       timeout;
  } ctrl_t;

  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/legv8_opcode_class.sv
// Combinational IR[31:21] -> instruction class decode, shared with the
// single-cycle control. Earlier matches take priority.
module legv8_opcode_class
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode_i,
  output op_class_e   cls_o
);

  always_comb begin
    cls_o = CLS_ILLEGAL;
    if (opcode_i[10:5] == OP_B_PFX)                cls_o = CLS_B;
    else if (opcode_i[10:3] == OP_CBZ_PFX)         cls_o = CLS_CBZ;
    else if (opcode_i == OP_LDUR)                  cls_o = CLS_LD;
    else if (opcode_i == OP_STUR)                  cls_o = CLS_ST;
    else if (opcode_i == OP_ADD || opcode_i == OP_SUB ||
             opcode_i == OP_AND || opcode_i == OP_ORR) cls_o = CLS_R;
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM with a shared req/ack memory port and a
// watchdog that aborts to IDLE when an access stalls too long.
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        pc_source,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  imm_sel,
  output logic        reg2loc,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        illegal,
  output logic        timeout
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  op_class_e        cls;
  ctrl_t            c;
  state_e           boundary;
  logic             wd_limit;

  // The zero flag qualifies pc_write_cond inside the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  legv8_opcode_class u_cls (
    .opcode_i (opcode),
    .cls_o    (cls)
  );

  assign boundary = run ? S_FETCH : S_IDLE;
  assign wd_limit = (wd_q == CNT_W'(MEM_TIMEOUT - 1)) && !mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    c       = '0;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        if (mem_ack) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.reg2loc   = (cls == CLS_ST) || (cls == CLS_CBZ);
        unique case (cls)
          CLS_B:          begin c.imm_sel = IMM_B;  state_d = S_JUMP;   end
          CLS_CBZ:        begin c.imm_sel = IMM_CB; state_d = S_BRANCH; end
          CLS_LD, CLS_ST: state_d = S_MEM_ADDR;
          CLS_R:          state_d = S_EXEC_R;
          default:        begin c.illegal = 1'b1; state_d = boundary; end
        endcase
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
        state_d     = S_WB_R;
      end
      S_WB_R: begin
        c.reg_write = 1'b1;
        state_d     = boundary;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.reg2loc   = (cls == CLS_ST);
        state_d     = (cls == CLS_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        c.mem_req = 1'b1;
        if (mem_ack) state_d = S_WB_LD;
      end
      S_MEM_WR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.reg2loc = 1'b1;
        if (mem_ack) state_d = boundary;
      end
      S_WB_LD: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        state_d      = boundary;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_PASS_B;
        c.reg2loc       = 1'b1;
        c.imm_sel       = IMM_CB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
        state_d         = boundary;
      end
      S_JUMP: begin
        c.imm_sel   = IMM_B;
        c.pc_write  = 1'b1;
        c.pc_source = 1'b1;
        state_d     = boundary;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort only fires without ack, so no enable was raised above this cycle.
    if (is_mem_state(state_q) && wd_limit) begin
      c.timeout = 1'b1;
      state_d   = S_IDLE;
    end
  end

  // Counts stalled request cycles; any state change or ack restarts it.
  always_comb begin
    wd_d = '0;
    if (state_d == state_q && is_mem_state(state_q) && !mem_ack)
      wd_d = wd_q + CNT_W'(1);
  end

  assign mem_req       = c.mem_req;
  assign mem_we        = c.mem_we;
  assign ir_write      = c.ir_write;
  assign pc_write      = c.pc_write;
  assign pc_write_cond = c.pc_write_cond;
  assign pc_source     = c.pc_source;
  assign alu_src_a     = c.alu_src_a;
  assign alu_src_b     = c.alu_src_b;
  assign alu_op        = c.alu_op;
  assign imm_sel       = c.imm_sel;
  assign reg2loc       = c.reg2loc;
  assign mem_to_reg    = c.mem_to_reg;
  assign reg_write     = c.reg_write;
  assign illegal       = c.illegal;
  assign timeout       = c.timeout;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Bench for the multi-cycle LEGv8 control: an instruction-step model checked
// every cycle, plus directed literal checks on the key cycles.
module tb_legv8_multicycle_ctrl;

  localparam int TMO = 16;
  localparam int C_ILL = 0, C_B = 1, C_CBZ = 2, C_LD = 3, C_ST = 4, C_R = 5;

  logic        clk, rst_n, run, zero, mem_ack;
  logic [10:0] opcode;
  logic        mem_req, mem_we, ir_write, pc_write, pc_write_cond, pc_source;
  logic        alu_src_a, reg2loc, mem_to_reg, reg_write, illegal, timeout;
  logic [1:0]  alu_src_b, alu_op, imm_sel;

  int n_run = 0, n_fail = 0;

  legv8_multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_sel(imm_sel), .reg2loc(reg2loc), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal(illegal), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [17:0] dut_v = {mem_req, mem_we, ir_write, pc_write, pc_write_cond, pc_source,
                       alu_src_a, alu_src_b, alu_op, imm_sel, reg2loc, mem_to_reg,
                       reg_write, illegal, timeout};

  task automatic chk(input string nm, input logic [17:0] got, input logic [17:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int op_cls(input logic [10:0] op);
    if (op[10:5] == 6'b000101)   return C_B;
    if (op[10:3] == 8'b10110100) return C_CBZ;
    if (op == 11'b11111000010)   return C_LD;
    if (op == 11'b11111000000)   return C_ST;
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return C_R;
    return C_ILL;
  endfunction

  // Expected outputs from the position inside the current instruction:
  // step 1 = fetch, 2 = decode, 3.. = class-specific steps.
  function automatic logic [17:0] model_out(input int step, input int cls, input int wt,
                                            input logic ack);
    logic rq, we, irw, pcw, pcc, pcs, sa, r2, mr, rw, ill, to;
    logic [1:0] sb, op, im;
    {rq, we, irw, pcw, pcc, pcs, sa, r2, mr, rw, ill, to} = '0;
    sb = 2'b00; op = 2'b00; im = 2'b00;
    if (step == 1) begin
      rq = 1; sb = 2'b01; irw = ack; pcw = ack; to = !ack && wt == TMO - 1;
    end else if (step == 2) begin
      sb = 2'b11;
      im = (cls == C_B) ? 2'b10 : (cls == C_CBZ) ? 2'b01 : 2'b00;
      r2 = (cls == C_CBZ || cls == C_ST);
      ill = (cls == C_ILL);
    end else if (step == 3) begin
      if (cls == C_R) begin sa = 1; op = 2'b10; end
      if (cls == C_LD || cls == C_ST) begin sa = 1; sb = 2'b10; r2 = (cls == C_ST); end
      if (cls == C_CBZ) begin sa = 1; op = 2'b01; r2 = 1; im = 2'b01; pcc = 1; pcs = 1; end
      if (cls == C_B) begin im = 2'b10; pcw = 1; pcs = 1; end
    end else if (step == 4) begin
      if (cls == C_R) rw = 1;
      if (cls == C_LD || cls == C_ST) begin
        rq = 1; we = (cls == C_ST); r2 = (cls == C_ST); to = !ack && wt == TMO - 1;
      end
    end else if (step == 5) begin
      rw = 1; mr = 1;
    end
    return {rq, we, irw, pcw, pcc, pcs, sa, sb, op, im, r2, mr, rw, ill, to};
  endfunction

  int m_step = 0, m_wait = 0;

  always @(negedge clk) begin
    int cls;
    logic is_mem, last;
    cls = op_cls(opcode);
    if (!rst_n) begin
      chk("model_reset", dut_v, 18'h0);
      m_step = 0; m_wait = 0;
    end else begin
      chk("model", dut_v, model_out(m_step, cls, m_wait, mem_ack));
      is_mem = (m_step == 1) || (m_step == 4 && (cls == C_LD || cls == C_ST));
      last = (cls == C_ILL && m_step == 2) || ((cls == C_B || cls == C_CBZ) && m_step == 3) ||
             ((cls == C_R || cls == C_ST) && m_step == 4) || (cls == C_LD && m_step == 5);
      if (m_step == 0) m_step = run ? 1 : 0;
      else if (is_mem && !mem_ack) begin
        if (m_wait == TMO - 1) begin m_step = 0; m_wait = 0; end
        else m_wait++;
      end else if (last) begin m_step = run ? 1 : 0; m_wait = 0; end
      else begin m_step++; m_wait = 0; end
    end
  end

  // One cycle: inputs change just after the rising edge, outputs are
  // inspected just after the falling edge.
  task automatic drive(input logic r, input logic a);
    @(posedge clk); #1;
    run = r; mem_ack = a;
    @(negedge clk); #1;
  endtask

  initial begin
    int cnt;
    logic seen_ir, early_to;
    rst_n = 1'b1; run = 1'b0; mem_ack = 1'b0; zero = 1'b0; opcode = 11'b10001011000;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", dut_v, 18'h0);

    // ADD: FETCH->FETCH in 4 cycles
    @(posedge clk); #1; rst_n = 1'b1; run = 1'b1; mem_ack = 1'b0;
    @(negedge clk); #1; chk("idle_after_reset", dut_v, 18'h0);
    drive(1, 1); chk("add_fetch_irw", ir_write, 1);
    drive(1, 0); chk("add_decode_srcb", alu_src_b, 2'b11);
    drive(1, 0); chk("add_exec_aluop", alu_op, 2'b10);
    drive(1, 0); chk("add_wb_regw", reg_write, 1);
    drive(1, 1); chk("add_back_fetch", {mem_req, ir_write}, 2'b11);

    // Async reset in EXEC_R
    drive(1, 0);
    drive(1, 0); chk("exec_before_rst", alu_op, 2'b10);
    rst_n = 1'b0; #1; chk("rst_mid_exec", dut_v, 18'h0);
    drive(1, 0);
    @(posedge clk); #1; rst_n = 1'b1; run = 1'b1; mem_ack = 1'b0;
    @(negedge clk); #1; chk("idle_after_rel", dut_v, 18'h0);
    drive(1, 0); chk("fetch_after_rel", mem_req, 1);

    // LDUR with 3 wait cycles in MEM_RD
    opcode = 11'b11111000010;
    drive(1, 1); drive(1, 0); drive(1, 0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin drive(1, 0); cnt += int'(mem_req); end
    drive(1, 1); cnt += int'(mem_req);
    chk("ldur_req_cycles", 18'(cnt), 18'd4);
    drive(1, 0); chk("ldur_wb", {mem_to_reg, reg_write}, 2'b11);

    // STUR
    opcode = 11'b11111000000;
    drive(1, 1);
    drive(1, 0); chk("stur_decode_r2l", reg2loc, 1);
    drive(1, 0);
    drive(1, 1); chk("stur_memwr", {mem_req, mem_we, reg2loc}, 3'b111);

    // CBZ with zero=1
    opcode = 11'b10110100101; zero = 1'b1;
    drive(1, 1);
    drive(1, 0); chk("cbz_decode_imm", imm_sel, 2'b01);
    drive(1, 0); chk("cbz_branch", {pc_write_cond, pc_source}, 2'b11);

    // B
    opcode = 11'b00010111111;
    drive(1, 1);
    drive(1, 0); chk("b_decode_imm", imm_sel, 2'b10);
    drive(1, 0); chk("b_jump", {pc_write, pc_source}, 2'b11);

    // Ack never arrives in FETCH
    seen_ir = 1'b0; early_to = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      drive(1, 0);
      seen_ir |= ir_write;
      if (k < TMO) early_to |= timeout;
    end
    chk("timeout_16th", timeout, 1);
    chk("timeout_early", early_to, 0);
    chk("timeout_no_irw", seen_ir, 0);
    drive(0, 0); chk("idle_after_to", dut_v, 18'h0);

    // Ack on the limit cycle wins
    opcode = 11'b00000000000;
    drive(1, 0);
    for (int k = 1; k < TMO; k++) drive(1, 0);
    drive(1, 1); chk("ack_wins_limit", {timeout, ir_write}, 2'b01);

    // Illegal opcode: run=1 -> FETCH, run=0 -> IDLE
    drive(1, 0); chk("illegal_pulse", illegal, 1);
    drive(1, 1); chk("illegal_to_fetch", mem_req, 1);
    drive(0, 0); chk("illegal_pulse2", illegal, 1);
    drive(0, 1); chk("illegal_to_idle", dut_v, 18'h0);
    drive(0, 1); chk("ack_ignored_idle", dut_v, 18'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
